lock_controller: RTL and testbench

Consumes the one-cycle verdict pulses produced by the passcode-entry stage (synchronised, edge-detected buttons into the passcode FSM) and turns them into door-level behaviour. A correct code opens the lock for a fixed window. Consecutive wrong codes are counted, and reaching the limit raises an alarm and enforces a lockout during which all verdicts are ignored. It is the next stage downstream of the passcode block and drives the board's lock and alarm indicators.

---
 rtl/lock_pkg.sv | 19 +
 rtl/cycle_timer.sv | 22 ++
 rtl/lock_controller.sv | 112 +++++++++++
 tb/tb_lock_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and width helpers for the door lock controller.
package lock_pkg;

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } lock_state_t;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down counter that stops at zero; expire_c flags the last counted cycle.
module cycle_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expire_c
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               count <= '0;
      else if (load)            count <= value;
      else if (count != '0)     count <= count - W'(1);
   end

   assign expire_c = (count == W'(1));

endmodule

// File: rtl/lock_controller.sv
// Turns correct/incorrect passcode verdict pulses into unlock window, fail count and lockout alarm.
module lock_controller
   import lock_pkg::*;
#(
   parameter int unsigned UNLOCK_CYCLES  = 50,
   parameter int unsigned LOCKOUT_CYCLES = 100,
   parameter int unsigned MAX_FAIL       = 3
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             P2,
   input  logic                             P1,
   output logic                             Unlock,
   output logic                             Alarm,
   output logic [cnt_width(MAX_FAIL)-1:0]   FailCnt
);

   localparam int unsigned FW = cnt_width(MAX_FAIL);
   localparam int unsigned TW = cnt_width(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES));

   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
   localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
   localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES);
   localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES);

   lock_state_t   state;
   lock_state_t   state_nxt;
   logic [FW-1:0] fail_nxt;
   logic          tmr_load;
   logic [TW-1:0] tmr_value;
   logic          expire_c;

   // Single timer serves both the unlock window and the lockout period.
   cycle_timer #(.W(TW)) u_timer (
      .clk      (CLK),
      .rst_n    (RST),
      .load     (tmr_load),
      .value    (tmr_value),
      .expire_c (expire_c)
   );

   // P1 wins over P2 everywhere, so a double press is always a failure.
   always_comb begin
      state_nxt = state;
      fail_nxt  = FailCnt;
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state)
         LOCKED: begin
            if (P1) begin
               if (FailCnt == FAIL_LAST) begin
                  state_nxt = LOCKOUT;
                  fail_nxt  = FAIL_MAX;
                  tmr_load  = 1'b1;
                  tmr_value = T_LOCKOUT;
               end else begin
                  fail_nxt = FailCnt + FW'(1);
               end
            end else if (P2) begin
               state_nxt = OPEN;
               fail_nxt  = '0;
               tmr_load  = 1'b1;
               tmr_value = T_UNLOCK;
            end
         end
         OPEN: begin
            if (P1) begin
               if (MAX_FAIL == 1) begin
                  state_nxt = LOCKOUT;
                  fail_nxt  = FAIL_MAX;
                  tmr_load  = 1'b1;
                  tmr_value = T_LOCKOUT;
               end else begin
                  state_nxt = LOCKED;
                  fail_nxt  = FW'(1);
               end
            end else if (P2) begin
               tmr_load  = 1'b1;
               tmr_value = T_UNLOCK;
            end else if (expire_c) begin
               state_nxt = LOCKED;
            end
         end
         LOCKOUT: begin
            if (expire_c) begin
               state_nxt = LOCKED;
               fail_nxt  = '0;
            end
         end
         default: begin
            state_nxt = LOCKED;
            fail_nxt  = '0;
         end
      endcase
   end

   // Indicators are registered alongside the state they decode.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= LOCKED;
         FailCnt <= '0;
         Unlock  <= 1'b0;
         Alarm   <= 1'b0;
      end else begin
         state   <= state_nxt;
         FailCnt <= fail_nxt;
         Unlock  <= (state_nxt == OPEN);
         Alarm   <= (state_nxt == LOCKOUT);
      end
   end

endmodule

// File: tb/tb_lock_controller.sv
// Randomised and directed checks of lock_controller against a deadline-based reference model.
module tb_lock_controller;

   localparam int UNL = 4;
   localparam int LCK = 6;
   localparam int MXF = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       P1  = 1'b0;
   logic       P2  = 1'b0;
   logic       Unlock;
   logic       Alarm;
   logic [1:0] FailCnt;

   int total = 0;
   int bad   = 0;

   // Model: cycle index plus the last cycle each indicator is due to stay high.
   int cyc      = 0;
   int open_end = -1;
   int lock_end = -1;
   int m_fails  = 0;
   bit exp_u;
   bit exp_a;
   logic [1:0] exp_f;

   lock_controller #(
      .UNLOCK_CYCLES  (UNL),
      .LOCKOUT_CYCLES (LCK),
      .MAX_FAIL       (MXF)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .P2      (P2),
      .P1      (P1),
      .Unlock  (Unlock),
      .Alarm   (Alarm),
      .FailCnt (FailCnt)
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      cyc      = 0;
      open_end = -1;
      lock_end = -1;
      m_fails  = 0;
      exp_u    = 1'b0;
      exp_a    = 1'b0;
      exp_f    = 2'd0;
   endtask

   // Verdict seen at the edge ending cycle cyc; result is for cycle cyc+1.
   task automatic model_edge(input bit a, input bit b);
      if (cyc <= lock_end) begin
         if (cyc == lock_end) m_fails = 0;
      end else if (a) begin
         m_fails  = m_fails + 1;
         open_end = cyc;
         if (m_fails >= MXF) begin
            m_fails  = MXF;
            lock_end = cyc + LCK;
         end
      end else if (b) begin
         open_end = cyc + UNL;
         m_fails  = 0;
      end
      cyc   = cyc + 1;
      exp_u = (cyc <= open_end);
      exp_a = (cyc <= lock_end);
      exp_f = 2'(m_fails);
   endtask

   task automatic drive(input bit a, input bit b);
      @(negedge CLK);
      P1 = a;
      P2 = b;
      @(posedge CLK);
      model_edge(a, b);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      P1  = 1'b0;
      P2  = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (Unlock !== 1'b0 || Alarm !== 1'b0 || FailCnt !== 2'd0) begin
         bad++;
         $display("FAIL reset_init got u=%b a=%b f=%0d want 0 0 0", Unlock, Alarm, FailCnt);
      end
      // Async reset while OPEN with a nonzero count history.
      drive(1, 0);
      drive(0, 1);
      drive(0, 0);
      #2 RST = 1'b0;
      #1;
      total++;
      if (Unlock !== 1'b0 || Alarm !== 1'b0 || FailCnt !== 2'd0) begin
         bad++;
         $display("FAIL reset_open got u=%b a=%b f=%0d want 0 0 0", Unlock, Alarm, FailCnt);
      end
      @(negedge CLK);
      RST = 1'b1;
      model_reset();
      // Async reset while in LOCKOUT.
      for (int i = 0; i < 4; i++) drive(i < 3, 0);
      #2 RST = 1'b0;
      #1;
      total++;
      if (Unlock !== 1'b0 || Alarm !== 1'b0 || FailCnt !== 2'd0) begin
         bad++;
         $display("FAIL reset_lockout got u=%b a=%b f=%0d want 0 0 0", Unlock, Alarm, FailCnt);
      end
      @(negedge CLK);
      RST = 1'b1;
      model_reset();
      drive(0, 1);
      total++;
      if (Unlock !== 1'b1 || Alarm !== 1'b0 || FailCnt !== 2'd0) begin
         bad++;
         $display("FAIL reset_first_edge got u=%b a=%b f=%0d want 1 0 0", Unlock, Alarm, FailCnt);
      end
   endtask

   task automatic test_single_unlock();
      int hi = 0;
      do_reset();
      drive(0, 1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) drive(0, 0);
         hi += int'(Unlock);
         total++;
         if (Unlock !== exp_u || Alarm !== exp_a || FailCnt !== exp_f) begin
            bad++;
            $display("FAIL single_unlock c%0d got u=%b a=%b f=%0d want u=%b a=%b f=%0d",
                     i, Unlock, Alarm, FailCnt, exp_u, exp_a, exp_f);
         end
      end
      total++;
      if (hi !== UNL) begin
         bad++;
         $display("FAIL single_unlock_len got %0d want %0d", hi, UNL);
      end
   endtask

   task automatic test_success_clears();
      bit a_seq [3] = '{1, 1, 0};
      logic [1:0] f_seq [3] = '{2'd1, 2'd2, 2'd0};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(a_seq[i], !a_seq[i]);
         total++;
         if (FailCnt !== f_seq[i] || FailCnt !== exp_f || Alarm !== 1'b0 || Unlock !== exp_u) begin
            bad++;
            $display("FAIL success_clears s%0d got u=%b a=%b f=%0d want u=%b a=0 f=%0d",
                     i, Unlock, Alarm, FailCnt, exp_u, f_seq[i]);
         end
      end
      total++;
      if (Unlock !== 1'b1) begin
         bad++;
         $display("FAIL success_unlock got %b want 1", Unlock);
      end
   endtask

   task automatic test_lockout();
      int hi = 0;
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, 0);
      total++;
      if (FailCnt !== 2'd3 || Alarm !== 1'b1) begin
         bad++;
         $display("FAIL lockout_entry got a=%b f=%0d want a=1 f=3", Alarm, FailCnt);
      end
      hi = 1;
      for (int i = 0; i < 7; i++) begin
         drive(0, 1'($urandom_range(0, 1)));
         hi += int'(Alarm);
         total++;
         if (Unlock !== exp_u || Alarm !== exp_a || FailCnt !== exp_f) begin
            bad++;
            $display("FAIL lockout c%0d got u=%b a=%b f=%0d want u=%b a=%b f=%0d",
                     i, Unlock, Alarm, FailCnt, exp_u, exp_a, exp_f);
         end
      end
      total++;
      if (hi !== LCK) begin
         bad++;
         $display("FAIL lockout_len got %0d want %0d", hi, LCK);
      end
      // Verdict on the first cycle after exit is honoured.
      drive(0, 1);
      total++;
      if (Unlock !== 1'b1 || Alarm !== 1'b0 || FailCnt !== 2'd0) begin
         bad++;
         $display("FAIL lockout_exit got u=%b a=%b f=%0d want 1 0 0", Unlock, Alarm, FailCnt);
      end
   endtask

   task automatic test_open_extend();
      int hi = 0;
      do_reset();
      drive(0, 1);
      hi += int'(Unlock);
      for (int i = 1; i < 11; i++) begin
         drive(0, i == 3);
         hi += int'(Unlock);
         total++;
         if (Unlock !== exp_u || Alarm !== exp_a || FailCnt !== exp_f) begin
            bad++;
            $display("FAIL open_extend c%0d got u=%b a=%b f=%0d want u=%b a=%b f=%0d",
                     i, Unlock, Alarm, FailCnt, exp_u, exp_a, exp_f);
         end
      end
      total++;
      if (hi !== 3 + UNL) begin
         bad++;
         $display("FAIL open_extend_len got %0d want %0d", hi, 3 + UNL);
      end
   endtask

   task automatic test_open_fail();
      do_reset();
      drive(0, 1);
      drive(0, 0);
      drive(1, 0);
      total++;
      if (Unlock !== 1'b0 || Alarm !== 1'b0 || FailCnt !== 2'd1) begin
         bad++;
         $display("FAIL open_fail got u=%b a=%b f=%0d want 0 0 1", Unlock, Alarm, FailCnt);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      drive(1, 1);
      total++;
      if (Unlock !== 1'b0 || Alarm !== 1'b0 || FailCnt !== 2'd1) begin
         bad++;
         $display("FAIL simultaneous got u=%b a=%b f=%0d want 0 0 1", Unlock, Alarm, FailCnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
         total++;
         if (Unlock !== exp_u || Alarm !== exp_a || FailCnt !== exp_f) begin
            bad++;
            $display("FAIL random c%0d got u=%b a=%b f=%0d want u=%b a=%b f=%0d",
                     i, Unlock, Alarm, FailCnt, exp_u, exp_a, exp_f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_unlock();
      test_success_clears();
      test_lockout();
      test_open_extend();
      test_open_fail();
      test_simultaneous();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
